pll_reset_ctrl: RTL and testbench

Reset and power sequencer for the iCE40 `SB_PLL40_2F_CORE` wrapper. It runs on the board reference clock and drives the PLL's active-low `RESET` and `LATCHINPUTVALUE` inputs. It qualifies the PLL `LOCK` output and releases a system reset only after lock has been stable. It also retries on lock timeout or lock loss, and handles a sleep/wake handshake that freezes the PLL outputs through the ICEGATE latch.

---
 rtl/pll_reset_ctrl.sv | 152 +++++++++++++++
 tb/tb_pll_reset_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: iCE40 PLL reset/lock sequencer with retry, fail and sleep/wake.
// In: REFERENCECLK, RESET(n), PLL_LOCK(async), SLEEP_REQ. Out: PLL_RESETB, PLL_LATCH, SYS_RESETN, PLL_READY, SLEEP_ACK, PLL_FAIL, RETRY_CNT[3:0].
module pll_reset_ctrl #(
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_STABLE  = 64,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       REFERENCECLK,
  input  logic       RESET,
  input  logic       PLL_LOCK,
  input  logic       SLEEP_REQ,
  output logic       PLL_RESETB,
  output logic       PLL_LATCH,
  output logic       SYS_RESETN,
  output logic       PLL_READY,
  output logic       SLEEP_ACK,
  output logic       PLL_FAIL,
  output logic [3:0] RETRY_CNT
);

  localparam int WAKE_CYCLES = 4;
  localparam int CMAX0 =
    (RESET_CYCLES > LOCK_STABLE) ? RESET_CYCLES : LOCK_STABLE;
  localparam int CMAX =
    (CMAX0 > WAKE_CYCLES) ? CMAX0 : WAKE_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PRST, WAITLK, STABLE, RUN, SLEEP, WAKE, FAIL
  } state_t;

  state_t        st, nxt;
  logic [1:0]    sync;
  logic          lock_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [3:0]    cons, cons_n, cons_inc;
  logic [3:0]    retry_n, retry_inc;
  logic          tmo;

  assign lock_s    = sync[1];
  assign cons_inc  = cons + 4'd1;
  assign retry_inc = (RETRY_CNT == 4'hf) ?
                     RETRY_CNT : RETRY_CNT + 4'd1;

  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) sync <= 2'b00;
    else        sync <= {sync[0], PLL_LOCK};
  end

  // cnt is shared by PRST, STABLE and WAKE; it restarts on any state change.
  // tcnt runs across WAITLK/STABLE bounces so a flaky lock still times out.
  always_comb begin
    nxt     = st;
    cnt_n   = '0;
    tcnt_n  = '0;
    cons_n  = cons;
    retry_n = RETRY_CNT;
    tmo     = 1'b0;
    unique case (st)
      PRST: begin
        cnt_n = cnt + 1'b1;
        if (cnt == RST_LAST) nxt = WAITLK;
      end
      WAITLK: begin
        tcnt_n = tcnt + 1'b1;
        if (tcnt == TO_LAST) tmo = 1'b1;
        else if (lock_s)     nxt = STABLE;
      end
      STABLE: begin
        tcnt_n = tcnt + 1'b1;
        cnt_n  = cnt + 1'b1;
        if (lock_s && cnt == STB_LAST) begin
          nxt    = RUN;
          cons_n = '0;
        end else if (tcnt == TO_LAST) begin
          tmo = 1'b1;
        end else if (!lock_s) begin
          nxt = WAITLK;
        end
      end
      RUN: begin
        if (!lock_s) begin
          nxt     = PRST;
          retry_n = retry_inc;
        end else if (SLEEP_REQ) begin
          nxt = SLEEP;
        end
      end
      SLEEP: if (!SLEEP_REQ) nxt = WAKE;
      WAKE: begin
        cnt_n = cnt + 1'b1;
        if (cnt == WAKE_LAST) nxt = RUN;
      end
      FAIL:    nxt = FAIL;
      default: nxt = PRST;
    endcase
    if (tmo) begin
      cons_n  = cons_inc;
      retry_n = retry_inc;
      nxt     = (cons_inc == RETRY_LIM) ? FAIL : PRST;
    end
    if (nxt != st) cnt_n = '0;
  end

  // {resetb, latch, sys_resetn, ready, sleep_ack, fail}
  function automatic logic [5:0] decode(state_t s);
    unique case (s)
      PRST:    decode = 6'b000000;
      WAITLK:  decode = 6'b100000;
      STABLE:  decode = 6'b100000;
      RUN:     decode = 6'b101100;
      SLEEP:   decode = 6'b111010;
      WAKE:    decode = 6'b101000;
      FAIL:    decode = 6'b000001;
      default: decode = 6'b000000;
    endcase
  endfunction

  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      st         <= PRST;
      cnt        <= '0;
      tcnt       <= '0;
      cons       <= '0;
      RETRY_CNT  <= '0;
      PLL_RESETB <= 1'b0;
      PLL_LATCH  <= 1'b0;
      SYS_RESETN <= 1'b0;
      PLL_READY  <= 1'b0;
      SLEEP_ACK  <= 1'b0;
      PLL_FAIL   <= 1'b0;
    end else begin
      st        <= nxt;
      cnt       <= cnt_n;
      tcnt      <= tcnt_n;
      cons      <= cons_n;
      RETRY_CNT <= retry_n;
      {PLL_RESETB, PLL_LATCH, SYS_RESETN,
       PLL_READY, SLEEP_ACK, PLL_FAIL} <= decode(nxt);
    end
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: directed/randomized bench for pll_reset_ctrl.
// Expected edge times come from arithmetic on the sequencing rules.
module tb_pll_reset_ctrl;

  localparam int RC = 16;
  localparam int LT = 4096;
  localparam int LS = 64;
  localparam int MR = 3;
  localparam int P  = RC + LT;

  localparam logic [9:0] M_ALL = 10'h3ff;

  logic       clk = 1'b0;
  logic       RESET, PLL_LOCK, SLEEP_REQ;
  logic       PLL_RESETB, PLL_LATCH, SYS_RESETN;
  logic       PLL_READY, SLEEP_ACK, PLL_FAIL;
  logic [3:0] RETRY_CNT;

  int edges  = 0;
  int base   = 0;
  int checks = 0;
  int errors = 0;

  pll_reset_ctrl #(
    .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT),
    .LOCK_STABLE(LS), .MAX_RETRIES(MR)
  ) dut (
    .REFERENCECLK(clk),
    .RESET(RESET),
    .PLL_LOCK(PLL_LOCK),
    .SLEEP_REQ(SLEEP_REQ),
    .PLL_RESETB(PLL_RESETB),
    .PLL_LATCH(PLL_LATCH),
    .SYS_RESETN(SYS_RESETN),
    .PLL_READY(PLL_READY),
    .SLEEP_ACK(SLEEP_ACK),
    .PLL_FAIL(PLL_FAIL),
    .RETRY_CNT(RETRY_CNT)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] outv();
    return {PLL_RESETB, PLL_LATCH, SYS_RESETN, PLL_READY,
            SLEEP_ACK, PLL_FAIL, RETRY_CNT};
  endfunction

  function automatic logic [9:0] mk(
    input logic rb, input logic lat, input logic sr,
    input logic rd, input logic ack, input logic fl,
    input int rc);
    return {rb, lat, sr, rd, ack, fl, 4'(rc)};
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Lock first sampled at edge lk, PLL reset pulse started at edge ps:
  // lock_s is seen two edges later, but not before WAITLK exists.
  function automatic int run_edge(input int lk, input int ps);
    return imax(lk + 2, ps + RC + 1) + LS;
  endfunction

  task automatic chk(input string tag,
                     input logic [9:0] obs,
                     input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Park on the falling edge that follows relative edge r.
  task automatic at(input int r);
    while (edges - base < r) @(negedge clk);
  endtask

  task automatic edge_chk(input string tag, input int e,
                          input logic [9:0] m,
                          input logic [9:0] pre,
                          input logic [9:0] post);
    at(e - 1);
    chk({tag, "_pre"}, outv() & m, pre & m);
    at(e);
    chk(tag, outv() & m, post & m);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    RESET     = 1'b0;
    PLL_LOCK  = 1'b0;
    SLEEP_REQ = 1'b0;
    #1 chk({tag, "_async"}, outv(), '0);
    @(negedge clk);
    chk(tag, outv(), '0);
    RESET = 1'b1;
    base  = edges;
  endtask

  initial begin
    int l, s, d, g, l2, r, r2, l3, w, ps, pl, a;
    RESET     = 1'b0;
    PLL_LOCK  = 1'b0;
    SLEEP_REQ = 1'b0;

    // clean bring-up
    do_reset("rst0");
    edge_chk("t1_prst", RC, M_ALL, mk(0,0,0,0,0,0,0),
             mk(1,0,0,0,0,0,0));
    l = 20 + int'($urandom_range(0, 20));
    at(l - 1);
    PLL_LOCK = 1'b1;
    r = run_edge(l, 0);
    edge_chk("t1_run", r, M_ALL, mk(1,0,0,0,0,0,0),
             mk(1,0,1,1,0,0,0));
    at(r + 10);
    chk("t1_hold", outv(), mk(1,0,1,1,0,0,0));

    // lock glitch while qualifying
    do_reset("rst1");
    l = 20 + int'($urandom_range(0, 10));
    at(l - 1);
    PLL_LOCK = 1'b1;
    s = l + 2;
    d = s + 38 + int'($urandom_range(0, 4));
    g = int'($urandom_range(1, 5));
    at(d - 1);
    PLL_LOCK = 1'b0;
    at(d + g - 1);
    PLL_LOCK = 1'b1;
    l2 = d + g;
    at(s + LS);
    chk("t2_norel", outv(), mk(1,0,0,0,0,0,0));
    r = run_edge(l2, 0);
    edge_chk("t2_run", r, M_ALL, mk(1,0,0,0,0,0,0),
             mk(1,0,1,1,0,0,0));

    // timeouts with a short false lock in the first attempt
    do_reset("rst2");
    ps = 500 + int'($urandom_range(0, 1000));
    pl = int'($urandom_range(2, 20));
    at(ps - 1);
    PLL_LOCK = 1'b1;
    at(ps + pl - 1);
    PLL_LOCK = 1'b0;
    for (int i = 1; i <= MR; i++) begin
      edge_chk($sformatf("t3_to%0d", i), i * P, M_ALL,
               mk(1,0,0,0,0,0,i - 1),
               mk(0,0,0,0,0,(i == MR),i));
      if (i < MR)
        edge_chk($sformatf("t3_rel%0d", i), i * P + RC,
                 M_ALL, mk(0,0,0,0,0,0,i),
                 mk(1,0,0,0,0,0,i));
    end
    at(MR * P + 50);
    PLL_LOCK = 1'b1;
    at(MR * P + 200);
    chk("t3_fail_hold", outv(), mk(0,0,0,0,0,1,MR));

    // lock loss in RUN coinciding with a sleep request
    do_reset("rst3");
    l = 20 + int'($urandom_range(0, 10));
    at(l - 1);
    PLL_LOCK = 1'b1;
    r = run_edge(l, 0);
    edge_chk("t4_run", r, M_ALL, mk(1,0,0,0,0,0,0),
             mk(1,0,1,1,0,0,0));
    d = r + 5 + int'($urandom_range(0, 20));
    at(d - 1);
    PLL_LOCK = 1'b0;
    at(d + 1);
    chk("t4_loss_pre", outv(), mk(1,0,1,1,0,0,0));
    SLEEP_REQ = 1'b1;
    at(d + 2);
    chk("t4_loss", outv(), mk(0,0,0,0,0,0,1));
    at(d + 10);
    chk("t4_prst_noack", outv(), mk(0,0,0,0,0,0,1));
    l3 = d + 2 + int'($urandom_range(10, 30));
    at(l3 - 1);
    PLL_LOCK = 1'b1;
    r2 = run_edge(l3, d + 2);
    edge_chk("t4_run2", r2, M_ALL, mk(1,0,0,0,0,0,1),
             mk(1,0,1,1,0,0,1));
    edge_chk("t5_sleep", r2 + 1, M_ALL, mk(1,0,1,1,0,0,1),
             mk(1,1,1,0,1,0,1));

    // sleep: lock drop is ignored, wake flushes the synchronizer
    at(r2 + 3);
    PLL_LOCK = 1'b0;
    at(r2 + 3 + int'($urandom_range(3, 15)));
    PLL_LOCK = 1'b1;
    at(r2 + 25);
    chk("t5_sleep_hold", outv(), mk(1,1,1,0,1,0,1));
    w = r2 + 30 + int'($urandom_range(0, 10));
    at(w - 1);
    SLEEP_REQ = 1'b0;
    PLL_LOCK  = 1'b0;
    edge_chk("t5_wake", w, M_ALL, mk(1,1,1,0,1,0,1),
             mk(1,0,1,0,0,0,1));
    PLL_LOCK = 1'b1;
    edge_chk("t5_ready", w + 4, M_ALL, mk(1,0,1,0,0,0,1),
             mk(1,0,1,1,0,0,1));
    at(w + 20);
    chk("t5_run_hold", outv(), mk(1,0,1,1,0,0,1));

    // asynchronous reset pulse in WAITLK
    do_reset("rst4");
    a = 20 + int'($urandom_range(0, 30));
    at(a);
    chk("t6_waitlk", outv(), mk(1,0,0,0,0,0,0));
    RESET = 1'b0;
    #1 chk("t6_async", outv(), '0);
    #3 RESET = 1'b1;
    base = edges;
    edge_chk("t6_restart", RC, M_ALL, mk(0,0,0,0,0,0,0),
             mk(1,0,0,0,0,0,0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
